upsampling: RTL and testbench
=============================

// Module: upsampling
// PURPOSE
//  Rate expander on the 8-bit sample path, the converse of the decimator: each accepted sample
//  is expanded into FACTOR output samples, one per iTick strobe. Sits between the sample
//  source/capture path and the consumer (display/DAC/UART sink). Zero-order hold by default,
//  linear interpolation when UPSAMPLING_LERP_EN is defined.
// PARAMETERS
//  LOG2_FACTOR  2   expansion factor FACTOR = 2**LOG2_FACTOR (1..8); power of two keeps shifts exact
//  DATA_W       8   sample width
// PORTS
//  iClk         in   1       single clock, all logic rising-edge
//  iRst_n       in   1       asynchronous, active-low reset
//  iTick        in   1       output-rate strobe; one output sample per high cycle
//  iData        in   DATA_W  input sample
//  iData_Valid  in   1       input sample valid; transfer when iData_Valid && oReady
//  oReady       out  1       input buffer free (= !nxt_valid)
//  oData        out  DATA_W  output sample, registered
//  oData_Valid  out  1       one-cycle pulse, oData valid
//  oUnderrun    out  1       one-cycle pulse: iTick arrived with no segment to emit
// BEHAVIOUR
//  - Storage: cur (sample being expanded), nxt + nxt_valid (one-entry input buffer), phase[LOG2_FACTOR-1:0].
//  - Reset (async, iRst_n=0): state EMPTY, phase 0, nxt_valid 0; oData 0, oData_Valid 0,
//    oUnderrun 0, oReady 1. Reset mid-segment discards cur/nxt; no partial output afterwards.
//  - Input: transfer writes nxt, sets nxt_valid. oReady is registered-state only, no comb path from inputs.
//  - States: EMPTY (no cur), WAIT (cur held, next segment not startable), RUN (emitting).
//    ZOH:  EMPTY/WAIT & nxt_valid -> cur<=nxt, clear nxt_valid, phase 0, RUN. WAIT unused.
//    LERP: EMPTY & nxt_valid -> cur<=nxt, clear nxt_valid, WAIT (priming, no output).
//          WAIT & nxt_valid -> RUN, phase 0 (segment cur->nxt; nxt kept until segment end).
//  - RUN & iTick: oData<=f(cur,nxt,phase), oData_Valid pulse next cycle (latency 1 from iTick);
//    phase++. On phase==FACTOR-1 (last emit):
//      ZOH:  nxt_valid ? (cur<=nxt, clear, phase 0, RUN) : EMPTY.
//      LERP: cur<=nxt, clear nxt_valid, WAIT (next segment starts once a new sample lands).
//    Back-to-back segments with buffered data: no tick lost, no bubble.
//  - iTick in EMPTY/WAIT: oUnderrun pulse, oData_Valid 0, oData holds last value.
//  - iTick low: nothing emitted, phase holds. Input transfer and tick in same cycle are independent;
//    a sample arriving that cycle is not used until the following cycle.
//  - f (ZOH): cur. f (LERP): cur + ((nxt - cur) * phase) >>> LOG2_FACTOR; diff signed DATA_W+1,
//    product signed DATA_W+1+LOG2_FACTOR, arithmetic shift (floor). Result always within [min,max]
//    of cur,nxt, truncated to DATA_W without overflow. phase 0 emits cur exactly.
// CONFIGURATION
//  UPSAMPLING_LERP_EN defined: linear interpolation, WAIT state used, 1-sample priming latency.
//  Not defined: zero-order hold, lerp datapath and WAIT state absent from netlist.
// STRUCTURE
//  - Shared package scope_pkg: SAMPLE_W=8, upsample state enum {EMPTY, WAIT, RUN}.
//  - One sub-module upsampling_lerp (combinational: cur, nxt, phase -> value), instantiated only
//    under UPSAMPLING_LERP_EN; FSM, buffer and output registers stay in upsampling.
// TESTING (LOG2_FACTOR=2, iTick every cycle unless noted)
//  1 ZOH: push 0x10 then 0x20 -> oData 10,10,10,10,20,20,20,20 contiguous, then oUnderrun pulses.
//  2 LERP: push 0, 100, 0 -> 0,25,50,75, then 100,75,50,25; rounding: push 0,3,0 -> 0,0,1,2,3,2,1,0.
//  3 Backpressure: hold iData_Valid high with ramp 1,2,3.. -> oReady low while nxt full, no sample
//    dropped or duplicated, output = each value x4 in order.
//  4 iTick every 3rd cycle -> oData_Valid only on cycle after each tick, phase advances only on ticks.
//  5 Underrun: ticks with no input -> oUnderrun per tick, oData_Valid 0, oData holds.
//  6 Assert iRst_n=0 at phase 2 mid-segment -> outputs 0, oReady 1 immediately; no stale output after release.

Source files
------------

// File: rtl/scope_pkg.sv
// Definitions shared by the sample-path blocks: the sample width and the upsampler state encoding.
package scope_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {
    EMPTY,
    WAIT,
    RUN
  } upsample_state_t;

endpackage

// File: rtl/upsampling_lerp.sv
// Combinational interpolation point: cur + floor((nxt - cur) * phase / FACTOR).
// The result always lies between cur and nxt, so truncating it to DATA_W bits is exact.
module upsampling_lerp
  import scope_pkg::*;
#(
  parameter int LOG2_FACTOR = 2,
  parameter int DATA_W      = SAMPLE_W
) (
  input  logic [DATA_W-1:0]      cur,
  input  logic [DATA_W-1:0]      nxt,
  input  logic [LOG2_FACTOR-1:0] phase,
  output logic [DATA_W-1:0]      value
);

  localparam int PW = DATA_W + 1 + LOG2_FACTOR;

  logic signed [DATA_W:0] diff;
  logic signed [PW-1:0]   diff_ext;
  logic signed [PW-1:0]   phase_ext;
  logic signed [PW-1:0]   cur_ext;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   shifted;

  // All operands are widened to one common signed width so the arithmetic shift floors negative steps
  always_comb begin
    diff      = $signed({1'b0, nxt}) - $signed({1'b0, cur});
    diff_ext  = $signed({{LOG2_FACTOR{diff[DATA_W]}}, diff});
    phase_ext = $signed({{(DATA_W + 1){1'b0}}, phase});
    cur_ext   = $signed({{(LOG2_FACTOR + 1){1'b0}}, cur});
    prod      = diff_ext * phase_ext;
    shifted   = prod >>> LOG2_FACTOR;
    value     = DATA_W'(cur_ext + shifted);
  end

endmodule

// File: rtl/upsampling.sv
// Rate expander: each accepted sample yields 2**LOG2_FACTOR outputs, one per iTick.
// Zero-order hold by default; define UPSAMPLING_LERP_EN for linear interpolation.
module upsampling
  import scope_pkg::*;
#(
  parameter int LOG2_FACTOR = 2,
  parameter int DATA_W      = SAMPLE_W
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iTick,
  input  logic [DATA_W-1:0] iData,
  input  logic              iData_Valid,
  output logic              oReady,
  output logic [DATA_W-1:0] oData,
  output logic              oData_Valid,
  output logic              oUnderrun
);

  upsample_state_t          state, state_d;
  logic [DATA_W-1:0]        cur, cur_d;
  logic [DATA_W-1:0]        nxt, nxt_d;
  logic                     nxt_valid, nxt_valid_d;
  logic [LOG2_FACTOR-1:0]   phase, phase_d;
  logic [DATA_W-1:0]        data_reg, data_d;
  logic                     valid_reg, valid_d;
  logic                     underrun_reg, underrun_d;
  logic [DATA_W-1:0]        emit_value;

`ifdef UPSAMPLING_LERP_EN
  upsampling_lerp #(
    .LOG2_FACTOR(LOG2_FACTOR),
    .DATA_W     (DATA_W)
  ) u_lerp (
    .cur  (cur),
    .nxt  (nxt),
    .phase(phase),
    .value(emit_value)
  );
`else
  assign emit_value = cur;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state        <= EMPTY;
      cur          <= '0;
      nxt          <= '0;
      nxt_valid    <= 1'b0;
      phase        <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state        <= state_d;
      cur          <= cur_d;
      nxt          <= nxt_d;
      nxt_valid    <= nxt_valid_d;
      phase        <= phase_d;
      data_reg     <= data_d;
      valid_reg    <= valid_d;
      underrun_reg <= underrun_d;
    end
  end

  // A sample is only accepted into an empty buffer, so it can never collide with a buffer consume
  always_comb begin
    state_d     = state;
    cur_d       = cur;
    nxt_d       = nxt;
    nxt_valid_d = nxt_valid;
    phase_d     = phase;
    data_d      = data_reg;
    valid_d     = 1'b0;
    underrun_d  = 1'b0;

    if (iData_Valid && !nxt_valid) begin
      nxt_d       = iData;
      nxt_valid_d = 1'b1;
    end

    case (state)
`ifdef UPSAMPLING_LERP_EN
      EMPTY: begin
        underrun_d = iTick;
        if (nxt_valid) begin
          cur_d       = nxt;
          nxt_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        underrun_d = iTick;
        if (nxt_valid) begin
          phase_d = '0;
          state_d = RUN;
        end
      end
`else
      EMPTY, WAIT: begin
        underrun_d = iTick;
        if (nxt_valid) begin
          cur_d       = nxt;
          nxt_valid_d = 1'b0;
          phase_d     = '0;
          state_d     = RUN;
        end
      end
`endif
      RUN: begin
        if (iTick) begin
          data_d  = emit_value;
          valid_d = 1'b1;
          phase_d = phase + 1'b1;
          if (&phase) begin
`ifdef UPSAMPLING_LERP_EN
            cur_d       = nxt;
            nxt_valid_d = 1'b0;
            state_d     = WAIT;
`else
            if (nxt_valid) begin
              cur_d       = nxt;
              nxt_valid_d = 1'b0;
              phase_d     = '0;
            end else begin
              state_d = EMPTY;
            end
`endif
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign oReady      = !nxt_valid;
  assign oData       = data_reg;
  assign oData_Valid = valid_reg;
  assign oUnderrun   = underrun_reg;

endmodule

// File: tb/tb_upsampling.sv
// Self-checking bench for upsampling (LOG2_FACTOR=2); expected streams come from a behavioural model.
module tb_upsampling;

  localparam int LOG2F = 2;
  localparam int F     = 4;

  typedef logic [7:0] sample_q[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       din_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       underrun;

  int n_cmp = 0;
  int n_fail = 0;

  sample_q obs;
  int      n_valid = 0;
  int      n_underrun = 0;
  int      bad_lat = 0;
  logic    last_tick = 1'b0;
  bit      saw_not_ready = 1'b0;

  always #5 clk = ~clk;

  upsampling #(
    .LOG2_FACTOR(LOG2F),
    .DATA_W     (8)
  ) dut (
    .iClk       (clk),
    .iRst_n     (rst_n),
    .iTick      (tick),
    .iData      (din),
    .iData_Valid(din_valid),
    .oReady     (ready),
    .oData      (dout),
    .oData_Valid(dout_valid),
    .oUnderrun  (underrun)
  );

  // Output collector: every pulse must follow a cycle whose edge saw iTick high
  always @(posedge clk) last_tick = tick;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_valid) begin
        obs.push_back(dout);
        n_valid++;
        if (!last_tick) bad_lat++;
      end
      if (underrun) begin
        n_underrun++;
        if (!last_tick) bad_lat++;
      end
    end
  end

  // Reference: ZOH repeats each sample FACTOR times; LERP walks each consecutive pair with floored steps
  function automatic sample_q model(sample_q s);
    sample_q e;
`ifdef UPSAMPLING_LERP_EN
    for (int i = 0; i + 1 < s.size(); i++) begin
      for (int p = 0; p < F; p++) begin
        int d, num, q;
        d   = int'(s[i+1]) - int'(s[i]);
        num = d * p;
        q   = num / F;
        if (num < 0 && (num % F) != 0) q = q - 1;
        e.push_back(8'(int'(s[i]) + q));
      end
    end
`else
    foreach (s[i]) for (int p = 0; p < F; p++) e.push_back(s[i]);
`endif
    return e;
  endfunction

  task automatic clear_counts();
    obs.delete();
    n_valid    = 0;
    n_underrun = 0;
    bad_lat    = 0;
  endtask

  task automatic do_reset();
    tick      = 1'b0;
    din_valid = 1'b0;
    din       = 8'h00;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_counts();
  endtask

  // period 0 means a random tick every cycle
  task automatic run_stream(input sample_q s, input int period, input int exp_count);
    int idx;
    bit ready_now;
    idx = 0;
    saw_not_ready = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (idx >= s.size() && n_valid >= exp_count) break;
      tick      = (period == 0) ? 1'($urandom_range(0, 1)) : ((cyc % period) == 0);
      din_valid = (idx < s.size());
      din       = din_valid ? s[idx] : 8'h00;
      ready_now = ready;
      if (din_valid && !ready_now) saw_not_ready = 1'b1;
      @(posedge clk);
      #1;
      if (din_valid && ready_now) idx++;
    end
    tick      = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic tick_cycles(input int n);
    tick = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp += 4;
    if (dout !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data got %h want 00", dout); end
    if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0", dout_valid); end
    if (underrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_underrun got %b want 0", underrun); end
    if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready got %b want 1", ready); end
    do_reset();
  endtask

`ifndef UPSAMPLING_LERP_EN
  task automatic test_zoh_sequence();
    sample_q s = '{8'h10, 8'h20};
    sample_q e = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h20, 8'h20, 8'h20, 8'h20};
    do_reset();
    run_stream(s, 1, e.size());
    n_cmp++;
    if (obs.size() != e.size()) begin n_fail++; $display("[TB] FAIL zoh_count got %0d want %0d", obs.size(), e.size()); end
    foreach (e[i]) begin
      n_cmp++;
      if (i >= obs.size() || obs[i] !== e[i]) begin
        n_fail++;
        $display("[TB] FAIL zoh_data[%0d] got %h want %h", i, (i < obs.size()) ? obs[i] : 8'hxx, e[i]);
      end
    end
    clear_counts();
    tick_cycles(3);
    n_cmp += 3;
    if (n_underrun != 3) begin n_fail++; $display("[TB] FAIL zoh_underrun got %0d want 3", n_underrun); end
    if (n_valid != 0) begin n_fail++; $display("[TB] FAIL zoh_idle_valid got %0d want 0", n_valid); end
    if (dout !== 8'h20) begin n_fail++; $display("[TB] FAIL zoh_hold got %h want 20", dout); end
  endtask
`else
  task automatic test_lerp_sequence();
    sample_q s1 = '{8'd0, 8'd100, 8'd0};
    sample_q e1 = '{8'd0, 8'd25, 8'd50, 8'd75, 8'd100, 8'd75, 8'd50, 8'd25};
    sample_q s2 = '{8'd0, 8'd3, 8'd0};
    sample_q e2 = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0};
    do_reset();
    run_stream(s1, 1, e1.size());
    foreach (e1[i]) begin
      n_cmp++;
      if (i >= obs.size() || obs[i] !== e1[i]) begin
        n_fail++;
        $display("[TB] FAIL lerp_ramp[%0d] got %h want %h", i, (i < obs.size()) ? obs[i] : 8'hxx, e1[i]);
      end
    end
    do_reset();
    run_stream(s2, 1, e2.size());
    foreach (e2[i]) begin
      n_cmp++;
      if (i >= obs.size() || obs[i] !== e2[i]) begin
        n_fail++;
        $display("[TB] FAIL lerp_round[%0d] got %h want %h", i, (i < obs.size()) ? obs[i] : 8'hxx, e2[i]);
      end
    end
  endtask
`endif

  task automatic test_backpressure();
    sample_q s, e;
    int base;
    base = $urandom_range(1, 200);
    for (int i = 0; i < 10; i++) s.push_back(8'(base + i));
    e = model(s);
    do_reset();
    run_stream(s, 1, e.size());
    n_cmp += 2;
    if (saw_not_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_ready_low got %b want 1", saw_not_ready); end
    if (obs.size() != e.size()) begin n_fail++; $display("[TB] FAIL bp_count got %0d want %0d", obs.size(), e.size()); end
    foreach (e[i]) begin
      n_cmp++;
      if (i >= obs.size() || obs[i] !== e[i]) begin
        n_fail++;
        $display("[TB] FAIL bp_data[%0d] got %h want %h", i, (i < obs.size()) ? obs[i] : 8'hxx, e[i]);
      end
    end
  endtask

  task automatic test_sparse_tick();
    sample_q s, e;
    for (int i = 0; i < 5; i++) s.push_back(8'($urandom_range(0, 255)));
    e = model(s);
    do_reset();
    run_stream(s, 3, e.size());
    n_cmp += 2;
    if (bad_lat != 0) begin n_fail++; $display("[TB] FAIL sparse_latency got %0d stray pulses want 0", bad_lat); end
    if (obs.size() != e.size()) begin n_fail++; $display("[TB] FAIL sparse_count got %0d want %0d", obs.size(), e.size()); end
    foreach (e[i]) begin
      n_cmp++;
      if (i >= obs.size() || obs[i] !== e[i]) begin
        n_fail++;
        $display("[TB] FAIL sparse_data[%0d] got %h want %h", i, (i < obs.size()) ? obs[i] : 8'hxx, e[i]);
      end
    end
  endtask

  task automatic test_underrun();
    sample_q s, e;
    logic [7:0] held;
    s = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    e = model(s);
    held = e[e.size()-1];
    do_reset();
    run_stream(s, 1, e.size());
    clear_counts();
    tick_cycles(5);
    n_cmp += 4;
    if (n_underrun != 5) begin n_fail++; $display("[TB] FAIL underrun_count got %0d want 5", n_underrun); end
    if (n_valid != 0) begin n_fail++; $display("[TB] FAIL underrun_valid got %0d want 0", n_valid); end
    if (dout !== held) begin n_fail++; $display("[TB] FAIL underrun_hold got %h want %h", dout, held); end
    if (bad_lat != 0) begin n_fail++; $display("[TB] FAIL underrun_latency got %0d want 0", bad_lat); end
  endtask

  task automatic test_reset_mid_segment();
    sample_q s = '{8'h55, 8'h66};
    int idx, emitted;
    bit ready_now;
    idx = 0;
    emitted = 0;
    do_reset();
    tick = 1'b1;
    for (int cyc = 0; cyc < 100 && emitted < 2; cyc++) begin
      din_valid = (idx < s.size());
      din       = din_valid ? s[idx] : 8'h00;
      ready_now = ready;
      @(posedge clk);
      #1;
      if (din_valid && ready_now) idx++;
      if (dout_valid) emitted++;
    end
    tick      = 1'b0;
    din_valid = 1'b0;
    n_cmp++;
    if (emitted != 2) begin n_fail++; $display("[TB] FAIL midreset_reach got %0d emits want 2", emitted); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (dout !== 8'h00) begin n_fail++; $display("[TB] FAIL midreset_data got %h want 00", dout); end
    if (dout_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_valid got %b want 0", dout_valid); end
    if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_ready got %b want 1", ready); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_counts();
    tick_cycles(6);
    n_cmp += 3;
    if (n_valid != 0) begin n_fail++; $display("[TB] FAIL midreset_stale got %0d outputs want 0", n_valid); end
    if (n_underrun != 6) begin n_fail++; $display("[TB] FAIL midreset_underrun got %0d want 6", n_underrun); end
    if (dout !== 8'h00) begin n_fail++; $display("[TB] FAIL midreset_hold got %h want 00", dout); end
  endtask

  task automatic test_random();
    sample_q s, e;
    for (int i = 0; i < 12; i++) s.push_back(8'($urandom_range(0, 255)));
    e = model(s);
    do_reset();
    run_stream(s, 0, e.size());
    n_cmp += 2;
    if (obs.size() != e.size()) begin n_fail++; $display("[TB] FAIL random_count got %0d want %0d", obs.size(), e.size()); end
    if (bad_lat != 0) begin n_fail++; $display("[TB] FAIL random_latency got %0d want 0", bad_lat); end
    foreach (e[i]) begin
      n_cmp++;
      if (i >= obs.size() || obs[i] !== e[i]) begin
        n_fail++;
        $display("[TB] FAIL random_data[%0d] got %h want %h", i, (i < obs.size()) ? obs[i] : 8'hxx, e[i]);
      end
    end
  endtask

  initial begin
    test_reset();
`ifndef UPSAMPLING_LERP_EN
    test_zoh_sequence();
`else
    test_lerp_sequence();
`endif
    test_backpressure();
    test_sparse_tick();
    test_underrun();
    test_reset_mid_segment();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
